fp_rsqrt_refine: RTL and testbench

//  Newton-Raphson refinement stage placed directly downstream of the fpRsqrte

---
 rtl/fp32_pkg.sv | 54 +++++
 rtl/fp32_mul_trunc.sv | 56 +++++
 rtl/fp_rsqrt_refine.sv | 187 ++++++++++++++++++
 tb/tb_fp_rsqrt_refine.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// FP32 field layout, special-value constants and the refinement FSM state type.
// Shared by the truncating multiplier and the rsqrt refinement stage.
// Also holds the special-operand classifier used when an operand is accepted.
package fp32_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [22:0] man;
    } fp32_t;

    localparam logic [31:0] FP_ONEP5 = 32'h3FC00000;
    localparam logic [31:0] FP_QNAN  = 32'h7FC00000;
    localparam logic [31:0] FP_PINF  = 32'h7F800000;
    localparam logic [31:0] FP_NINF  = 32'h7F800000 | 32'h80000000;

    // 2^-24: smallest step of the Q2.24 subtractor, used when 1.5 - t would go <= 0
    localparam logic [31:0] FP_SB_CLAMP = 32'h33800000;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQ   = 3'd1,
        MH   = 3'd2,
        SB   = 3'd3,
        MY   = 3'd4,
        DONE = 3'd5
    } rsq_state_e;

    typedef struct packed {
        logic        hit;
        logic [31:0] val;
    } rsq_special_t;

    // Operands that never enter the Newton loop, with their final result.
    // Priority: NaN, zero/denormal (signed inf), +inf, any other negative.
    function automatic rsq_special_t rsq_special(input fp32_t x);
        rsq_special_t r;
        r.hit = 1'b1;
        r.val = FP_QNAN;
        if (x.exp == 8'hFF && x.man != 23'd0) begin
            r.val = {x.sign, x.exp, 1'b1, x.man[21:0]};
        end else if (x.exp == 8'd0) begin
            r.val = x.sign ? FP_NINF : FP_PINF;
        end else if (x.sign) begin
            r.val = FP_QNAN;
        end else if (x.exp == 8'hFF) begin
            r.val = 32'h0000_0000;
        end else begin
            r.hit = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp32_mul_trunc.sv
// Combinational FP32 multiply with truncated mantissa and flush-to-zero.
// Latency 0 (pure combinational; the caller registers the product).
// No handshake; result is valid whenever the operands are.
//   a, b : FP32 operands
//   p    : FP32 product (denormal inputs/outputs flushed to signed zero)
module fp32_mul_trunc
    import fp32_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p
);

    fp32_t fa;
    fp32_t fb;
    logic [23:0] ma;
    logic [23:0] mb;
    logic [24:0] prod_hi;   // product bits [47:23]; lower bits are truncated away
    logic signed [9:0] e_sum;
    logic sgn;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign fa = a;
    assign fb = b;
    assign ma = {1'b1, fa.man};
    assign mb = {1'b1, fb.man};

    always_comb begin
        p       = 32'h0;
        sgn     = fa.sign ^ fb.sign;
        prod_hi = 25'(({24'd0, ma} * {24'd0, mb}) >> 23);
        e_sum   = $signed({2'b00, fa.exp}) + $signed({2'b00, fb.exp}) - 10'sd127
                  + $signed({9'd0, prod_hi[24]});
        a_nan   = (fa.exp == 8'hFF) && (fa.man != 23'd0);
        b_nan   = (fb.exp == 8'hFF) && (fb.man != 23'd0);
        a_inf   = (fa.exp == 8'hFF) && (fa.man == 23'd0);
        b_inf   = (fb.exp == 8'hFF) && (fb.man == 23'd0);
        a_zero  = (fa.exp == 8'd0);
        b_zero  = (fb.exp == 8'd0);

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            p = FP_QNAN;
        end else if (a_inf || b_inf) begin
            p = {sgn, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            p = {sgn, 31'd0};
        end else if (e_sum >= 10'sd255) begin
            p = {sgn, 8'hFF, 23'd0};
        end else if (e_sum <= 10'sd0) begin
            p = {sgn, 31'd0};
        end else begin
            p = {sgn, e_sum[7:0], prod_hi[24] ? prod_hi[23:1] : prod_hi[22:0]};
        end
    end

endmodule

// File: rtl/fp_rsqrt_refine.sv
// Newton-Raphson refinement of an FP32 1/sqrt(a) estimate: y' = y*(1.5 - (a/2)*y*y).
// Latency accept->o_valid = 4*NITER+1 ce-cycles; special operands take 2.
// Non-pipelined: i_ready only in IDLE; o_valid/o held in DONE until o_ready.
//   clk, rst_n (async, active low), ce (global hold when low)
//   i_valid/i_ready, a, y0 : operand and its estimate
//   o_valid/o_ready, o     : refined result
//   busy                   : any state other than IDLE
module fp_rsqrt_refine
    import fp32_pkg::*;
#(
    parameter int NITER = 2,
    parameter int FPWID = 32
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [FPWID-1:0] a,
    input  logic [FPWID-1:0] y0,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [FPWID-1:0] o,
    output logic             busy
);

    localparam int CW = $clog2(NITER + 1);
    localparam logic [CW-1:0] ITER_LAST = CW'(NITER - 1);
    localparam logic [24:0] ONEP5_Q = 25'h180_0000;   // 1.5 in Q2.24

    generate
        if (FPWID != 32) begin : g_bad_fpwid
            $error("fp_rsqrt_refine: only FPWID=32 is supported");
        end
        if (NITER < 1 || NITER > 4) begin : g_bad_niter
            $error("fp_rsqrt_refine: NITER must be 1..4");
        end
    endgenerate

    rsq_state_e state, state_n;
    logic [31:0] y;
    logic [31:0] t;
    logic [31:0] xh;
    logic [31:0] o_r;
    logic [CW-1:0] iter;
    logic spec_r;

    fp32_t a_f;
    rsq_special_t spc;
    logic [31:0] xh_in;

    assign a_f = a;
    assign spc = rsq_special(a_f);
    // a/2 by exponent decrement; the smallest normal would become denormal, so it flushes
    assign xh_in = (a_f.exp == 8'd1) ? 32'h0 : {a_f.sign, a_f.exp - 8'd1, a_f.man};

    // Shared multiplier, operands selected by state
    logic [31:0] mul_a, mul_b, mul_p;

    always_comb begin
        mul_a = y;
        mul_b = y;
        case (state)
            MH:      begin mul_a = xh; mul_b = t; end
            MY:      begin mul_a = y;  mul_b = t; end
            default: ;
        endcase
    end

    fp32_mul_trunc u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    // SB: r = 1.5 - t in unsigned Q2.24, renormalised to FP32.
    // sh = exp-126 is the left shift taking the 24-bit significand to Q2.24.
    fp32_t tf;
    logic signed [9:0] sh;
    logic [9:0]  amt;
    logic [24:0] fixed;
    logic [24:0] rdiff;
    logic [4:0]  lead;
    logic [22:0] rman;
    logic        clamp;
    logic [31:0] sb_res;

    assign tf = t;

    always_comb begin
        sh     = $signed({2'b00, tf.exp}) - 10'sd126;
        amt    = $unsigned(-sh);
        fixed  = 25'd0;
        clamp  = 1'b0;
        rdiff  = 25'd0;
        lead   = 5'd0;
        rman   = 23'd0;
        sb_res = FP_SB_CLAMP;
        // A negative t only arises from a negative operand, which never iterates
        if (tf.exp == 8'd0 || tf.sign) begin
            fixed = 25'd0;
        end else if (sh >= 10'sd2) begin
            clamp = 1'b1;                              // t >= 2, also inf/NaN
        end else if (sh == 10'sd1) begin
            fixed = {1'b1, tf.man, 1'b0};
        end else begin
            fixed = {1'b0, {1'b1, tf.man} >> amt};
        end
        if (fixed >= ONEP5_Q) begin
            clamp = 1'b1;
        end
        rdiff = ONEP5_Q - fixed;
        for (int i = 0; i < 25; i++) begin
            if (rdiff[i]) begin
                lead = 5'(i);
            end
        end
        // Leading one moved to bit 24 then dropped; one LSB is truncated when lead=24
        rman = 23'((rdiff << (5'd24 - lead)) >> 1);
        if (!clamp) begin
            sb_res = {1'b0, {3'b000, lead} + 8'd103, rman};
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (i_valid) state_n = SQ;
            SQ:      state_n = spec_r ? DONE : MH;
            MH:      state_n = SB;
            SB:      state_n = MY;
            MY:      state_n = (iter == ITER_LAST) ? DONE : SQ;
            DONE:    if (o_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            y      <= 32'h0;
            t      <= 32'h0;
            xh     <= 32'h0;
            o_r    <= 32'h0;
            iter   <= '0;
            spec_r <= 1'b0;
        end else if (ce) begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        spec_r <= spc.hit;
                        // special result parks in y and is copied out from SQ
                        y      <= spc.hit ? spc.val : y0;
                        xh     <= xh_in;
                        iter   <= '0;
                    end
                end
                SQ: begin
                    if (spec_r) begin
                        o_r <= y;
                    end else begin
                        t <= mul_p;
                    end
                end
                MH: t <= mul_p;
                SB: t <= sb_res;
                MY: begin
                    y    <= mul_p;
                    iter <= iter + CW'(1);
                    if (iter == ITER_LAST) begin
                        o_r <= mul_p;
                    end
                end
                default: ;
            endcase
        end
    end

    assign i_ready = (state == IDLE);
    assign o_valid = (state == DONE);
    assign busy    = (state != IDLE);
    assign o       = o_r;

endmodule

// File: tb/tb_fp_rsqrt_refine.sv
module tb_fp_rsqrt_refine;

    typedef struct {
        logic [31:0] val;
        int          tol;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, ce, o_ready;
    logic i_valid2, i_valid3;
    logic [31:0] a, y0;
    logic i_ready2, o_valid2, busy2;
    logic i_ready3, o_valid3, busy3;
    logic [31:0] o2, o3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t  exp2[$];
    exp_t  exp3[$];
    string nm2[$];
    string nm3[$];
    int    acc2[$];
    int    acc3[$];
    bit    pend2 = 0, pend3 = 0;
    logic [31:0] held2, held3, last2, ref1;

    always #5 clk = ~clk;

    fp_rsqrt_refine #(.NITER(2), .FPWID(32)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .i_valid(i_valid2), .i_ready(i_ready2),
        .a(a), .y0(y0), .o_valid(o_valid2), .o_ready(o_ready), .o(o2), .busy(busy2)
    );

    fp_rsqrt_refine #(.NITER(3), .FPWID(32)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .i_valid(i_valid3), .i_ready(i_ready3),
        .a(a), .y0(y0), .o_valid(o_valid3), .o_ready(o_ready), .o(o3), .busy(busy3)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want,
                       input int tol);
        longint d;
        checks++;
        d = longint'(got) - longint'(want);
        if (d < 0) d = -d;
        if ($isunknown(got) || d > longint'(tol)) begin
            errors++;
            $display("FAIL %s: got %h, want %h (tol %0d)", nm, got, want, tol);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    // Accept timestamps, taken at the edge that samples the handshake
    always @(posedge clk) begin
        if (rst_n && ce && i_valid2 && i_ready2) acc2.push_back(cyc);
        if (rst_n && ce && i_valid3 && i_ready3) acc3.push_back(cyc);
        cyc <= cyc + 1;
    end

    // Monitor for the NITER=2 instance
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid2) begin
                if (!pend2) begin
                    pend2 = 1;
                    held2 = o2;
                    if (acc2.size() == 0 || exp2.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL dut2_unexpected: o_valid with o=%h, nothing expected", o2);
                    end else begin
                        chk_int({nm2[0], "_lat"}, cyc - acc2.pop_front(), exp2[0].lat);
                    end
                end else begin
                    chk({"dut2_hold"}, o2, held2, 0);
                end
                if (o_ready && ce) begin
                    pend2 = 0;
                    last2 = o2;
                    if (exp2.size() > 0) begin
                        chk(nm2.pop_front(), o2, exp2[0].val, exp2[0].tol);
                        void'(exp2.pop_front());
                    end
                end
            end else if (pend2) begin
                pend2 = 0;
                checks++; errors++;
                $display("FAIL dut2_valid_drop: o_valid 0, want held 1");
            end
        end
    end

    // Monitor for the NITER=3 instance
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid3) begin
                if (!pend3) begin
                    pend3 = 1;
                    held3 = o3;
                    if (acc3.size() == 0 || exp3.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL dut3_unexpected: o_valid with o=%h, nothing expected", o3);
                    end else begin
                        chk_int({nm3[0], "_lat"}, cyc - acc3.pop_front(), exp3[0].lat);
                    end
                end else begin
                    chk("dut3_hold", o3, held3, 0);
                end
                if (o_ready && ce) begin
                    pend3 = 0;
                    if (exp3.size() > 0) begin
                        chk(nm3.pop_front(), o3, exp3[0].val, exp3[0].tol);
                        void'(exp3.pop_front());
                    end
                end
            end else if (pend3) begin
                pend3 = 0;
                checks++; errors++;
                $display("FAIL dut3_valid_drop: o_valid 0, want held 1");
            end
        end
    end

    // Inputs change 2 time units after the active edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input bit to3, input logic [31:0] av, input logic [31:0] yv,
                         input logic [31:0] ev, input int tol, input int lat,
                         input string nm, input bit expect_out);
        exp_t e;
        a  = av;
        y0 = yv;
        if (expect_out) begin
            e.val = ev; e.tol = tol; e.lat = lat;
            if (to3) begin exp3.push_back(e); nm3.push_back(nm); end
            else     begin exp2.push_back(e); nm2.push_back(nm); end
        end
        if (to3) i_valid3 = 1'b1; else i_valid2 = 1'b1;
        step();
        i_valid2 = 1'b0;
        i_valid3 = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && (exp2.size() != 0 || exp3.size() != 0); i++) step();
        if (exp2.size() != 0 || exp3.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d/%0d results outstanding, want 0",
                     exp2.size(), exp3.size());
            exp2.delete(); exp3.delete(); nm2.delete(); nm3.delete();
            acc2.delete(); acc3.delete();
            pend2 = 0; pend3 = 0;
        end
    endtask

    logic [31:0] sp_a [7] = '{32'h00000000, 32'h80000000, 32'hC0000000, 32'h7F800000,
                              32'h7FA00001, 32'h00400000, 32'hFF800000};
    logic [31:0] sp_e [7] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h00000000,
                              32'h7FE00001, 32'h7F800000, 32'h7FC00000};

    initial begin
        rst_n = 1'b0; ce = 1'b1; o_ready = 1'b1;
        i_valid2 = 1'b0; i_valid3 = 1'b0; a = 32'h0; y0 = 32'h0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        step();

        chk("rst_o", o2, 32'h0, 0);
        chk("rst_o_valid", {31'd0, o_valid2}, 32'h0, 0);
        chk("rst_i_ready", {31'd0, i_ready2}, 32'h1, 0);
        chk("rst_busy", {31'd0, busy2}, 32'h0, 0);

        // 1/sqrt(4) = 0.5; 128 bit-patterns stays inside 2^-16 relative on either side
        issue(0, 32'h40800000, 32'h3EF759DF, 32'h3F000000, 128, 9, "rsqrt4", 1);
        wait_drain();
        ref1 = last2;

        // NITER=3, 1/sqrt(1) with the consumer stalling 5 cycles
        o_ready = 1'b0;
        issue(1, 32'h3F800000, 32'h3F7759DF, 32'h3F800000, 4, 13, "rsqrt1_n3", 1);
        for (int i = 0; i < 100 && !o_valid3; i++) step();
        repeat (5) step();
        o_ready = 1'b1;
        wait_drain();

        // special operands: y0 is irrelevant, latency 2
        for (int k = 0; k < 7; k++) begin
            issue(0, sp_a[k], 32'h3F123456, sp_e[k], 0, 2, $sformatf("special%0d", k), 1);
            wait_drain();
        end

        // diverging estimate y0=2 for a=4: first SB clamps, result 1.5*2^-23
        issue(0, 32'h40800000, 32'h40000000, 32'h34400000, 0, 9, "diverge", 1);
        wait_drain();

        // reset while in MH of iteration 1
        issue(0, 32'h40800000, 32'h3EF759DF, 32'h0, 0, 0, "aborted", 0);
        step();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        acc2.delete();
        pend2 = 0;
        step();
        chk("abort_o", o2, 32'h0, 0);
        chk("abort_o_valid", {31'd0, o_valid2}, 32'h0, 0);
        chk("abort_i_ready", {31'd0, i_ready2}, 32'h1, 0);
        issue(0, 32'h40800000, 32'h3EF759DF, 32'h3F000000, 128, 9, "after_abort", 1);
        wait_drain();

        // ce low 3 cycles inside each of the 8 compute states, then 3 more in DONE
        issue(0, 32'h40800000, 32'h3EF759DF, 32'h3F000000, 128, 33, "ce_gaps", 1);
        for (int s = 0; s < 8; s++) begin
            ce = 1'b0;
            repeat (3) step();
            ce = 1'b1;
            step();
        end
        ce = 1'b0;
        repeat (3) step();
        ce = 1'b1;
        wait_drain();
        chk("ce_bitexact", last2, ref1, 0);

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
